// File: rtl/arm7_bdt_pkg.sv
// Shared definitions for the block data transfer (LDM/STM) engine.
//   - bdt_state_e : FSM states of block_data_transfer
//   - bdt_mode_e  : addressing modes, encoded as {pre, up}
//   - BDT_WORD_BYTES : default address stride per transferred register
//   - mode_of()   : packs pre/up into an addressing mode
package arm7_bdt_pkg;

    localparam int unsigned BDT_WORD_BYTES = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BASE_REQ,
        S_BASE_WAIT,
        S_SETUP,
        S_RD_REQ,
        S_RD_WAIT,
        S_MEM_WR,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_RF_WR,
        S_WB,
        S_DONE
    } bdt_state_e;

    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } bdt_mode_e;

    function automatic bdt_mode_e mode_of(input logic pre, input logic up);
        return bdt_mode_e'({pre, up});
    endfunction

endpackage

// File: rtl/block_data_transfer_if.sv
// Register-file and data-memory word ports shared by the LDM/STM engine.
//   master : the transfer engine (drives requests, receives read data)
//   slave  : register file / data memory side
// Read data (read_value, data_read_word_data) is valid the cycle after the
// corresponding request enable.
// Optional: BDT_S_BIT_EN adds read_user_bank (user-bank register reads).
interface block_data_transfer_if #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  write_en;
    logic [3:0]            write_reg;
    logic [DATA_WIDTH-1:0] write_value;
    logic                  write_restore_from_SPSR;
    logic                  read_en;
    logic [3:0]            read_reg;
    logic [DATA_WIDTH-1:0] read_value;
    logic                  data_write_word_en;
    logic [DATA_WIDTH-1:0] data_write_word_address;
    logic [DATA_WIDTH-1:0] data_write_word_data;
    logic                  data_read_word_en;
    logic [DATA_WIDTH-1:0] data_read_word_address;
    logic [DATA_WIDTH-1:0] data_read_word_data;
`ifdef BDT_S_BIT_EN
    logic                  read_user_bank;
`endif

    modport master (
        output write_en, write_reg, write_value, write_restore_from_SPSR,
        output read_en, read_reg,
`ifdef BDT_S_BIT_EN
        output read_user_bank,
`endif
        input  read_value,
        output data_write_word_en, data_write_word_address, data_write_word_data,
        output data_read_word_en, data_read_word_address,
        input  data_read_word_data
    );

    modport slave (
        input  write_en, write_reg, write_value, write_restore_from_SPSR,
        input  read_en, read_reg,
`ifdef BDT_S_BIT_EN
        input  read_user_bank,
`endif
        output read_value,
        input  data_write_word_en, data_write_word_address, data_write_word_data,
        input  data_read_word_en, data_read_word_address,
        output data_read_word_data
    );

endinterface

// File: rtl/bdt_reg_scan.sv
// Combinational register-list scanner for the LDM/STM engine.
//   reg_list_i : full register bitmap of the instruction
//   mask_i     : registers still to transfer
//   count_o    : popcount(reg_list_i)
//   idx_o      : lowest set bit of mask_i (next register to transfer)
//   last_o     : mask_i has exactly one bit set
module bdt_reg_scan #(
    parameter int unsigned REG_LIST_WIDTH = 16,
    parameter int unsigned IDX_W          = 4,
    parameter int unsigned CNT_W          = 5
) (
    input  logic [REG_LIST_WIDTH-1:0] reg_list_i,
    input  logic [REG_LIST_WIDTH-1:0] mask_i,
    output logic [CNT_W-1:0]          count_o,
    output logic [IDX_W-1:0]          idx_o,
    output logic                      last_o
);

    typedef logic [REG_LIST_WIDTH-1:0] list_t;

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < REG_LIST_WIDTH; i++) begin
            count_o = count_o + CNT_W'(reg_list_i[i]);
        end
    end

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        idx_o = '0;
        for (int unsigned i = REG_LIST_WIDTH; i > 0; i--) begin
            if (mask_i[i-1]) begin
                idx_o = IDX_W'(i - 1);
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
    assign last_o = (mask_i != '0) && ((mask_i & (mask_i - list_t'(1))) == '0);

endmodule

// File: rtl/block_data_transfer.sv
// Multi-register load/store engine (LDM/STM).
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   en              : start pulse, sampled only in IDLE
//   pre, up         : addressing mode (IA/IB/DA/DB)
//   write           : base write-back enable
//   load            : 1 = LDM, 0 = STM
//   rn              : base register
//   reg_list        : register bitmap, bit i = register i
//   busy, done      : busy from acceptance to completion; done pulses once
//   bus (master)    : register-file read/write and data-memory word ports
// Optional: define BDT_S_BIT_EN to add the s_bit input (SPSR restore on an
// R15 load, user-bank reads on store). Undefined: write_restore_from_SPSR=0.
module block_data_transfer
    import arm7_bdt_pkg::*;
#(
    parameter int unsigned REG_LIST_WIDTH = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WORD_BYTES     = BDT_WORD_BYTES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      pre,
    input  logic                      up,
    input  logic                      write,
    input  logic                      load,
    input  logic [3:0]                rn,
    input  logic [REG_LIST_WIDTH-1:0] reg_list,
`ifdef BDT_S_BIT_EN
    input  logic                      s_bit,
`endif
    output logic                      busy,
    output logic                      done,
    block_data_transfer_if.master     bus
);

    localparam int unsigned IDX_W = (REG_LIST_WIDTH > 1) ? $clog2(REG_LIST_WIDTH) : 1;
    localparam int unsigned CNT_W = $clog2(REG_LIST_WIDTH + 1);

    typedef logic [DATA_WIDTH-1:0]     word_t;
    typedef logic [REG_LIST_WIDTH-1:0] list_t;

    localparam word_t STRIDE     = word_t'(WORD_BYTES);
    localparam word_t ALIGN_MASK = ~word_t'(3);

    bdt_state_e       state_q, state_d;
    logic             pre_q, pre_d;
    logic             up_q, up_d;
    logic             write_q, write_d;
    logic             load_q, load_d;
    logic [3:0]       rn_q, rn_d;
    list_t            list_q, list_d;
    list_t            mask_q, mask_d;
    word_t            base_q, base_d;
    word_t            addr_q, addr_d;
    word_t            wb_q, wb_d;
    word_t            data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BDT_S_BIT_EN
    logic             s_bit_q, s_bit_d;
`endif

    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic             scan_last;

    bdt_reg_scan #(
        .REG_LIST_WIDTH (REG_LIST_WIDTH),
        .IDX_W          (IDX_W),
        .CNT_W          (CNT_W)
    ) u_scan (
        .reg_list_i (list_q),
        .mask_i     (mask_q),
        .count_o    (scan_cnt),
        .idx_o      (scan_idx),
        .last_o     (scan_last)
    );

    logic       rn_listed;
    bdt_state_e after_xfer;
    word_t      n_bytes;
    word_t      start_addr;

    // LDM that also loads the base register: the loaded value wins over write-back.
    assign rn_listed  = (list_q & (list_t'(1) << rn_q)) != '0;
    assign after_xfer = (write_q && !(load_q && rn_listed)) ? S_WB : S_DONE;
    assign n_bytes    = word_t'(cnt_q) * STRIDE;

    // Transfers always run upward from the lowest address, so descending
    // modes start N words below the base.
    always_comb begin
        start_addr = base_q;
        unique case (mode_of(pre_q, up_q))
            MODE_IA: start_addr = base_q;
            MODE_IB: start_addr = base_q + STRIDE;
            MODE_DA: start_addr = base_q - n_bytes + STRIDE;
            MODE_DB: start_addr = base_q - n_bytes;
            default: start_addr = base_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        up_d    = up_q;
        write_d = write_q;
        load_d  = load_q;
        rn_d    = rn_q;
        list_d  = list_q;
        mask_d  = mask_q;
        base_d  = base_q;
        addr_d  = addr_q;
        wb_d    = wb_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef BDT_S_BIT_EN
        s_bit_d = s_bit_q;
        bus.read_user_bank = 1'b0;
`endif
        busy = (state_q != S_IDLE) && (state_q != S_DONE);
        done = 1'b0;
        bus.write_en                = 1'b0;
        bus.write_reg               = '0;
        bus.write_value             = '0;
        bus.write_restore_from_SPSR = 1'b0;
        bus.read_en                 = 1'b0;
        bus.read_reg                = '0;
        bus.data_write_word_en      = 1'b0;
        bus.data_write_word_address = '0;
        bus.data_write_word_data    = '0;
        bus.data_read_word_en       = 1'b0;
        bus.data_read_word_address  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    pre_d   = pre;
                    up_d    = up;
                    write_d = write;
                    load_d  = load;
                    rn_d    = rn;
                    list_d  = reg_list;
                    mask_d  = reg_list;
`ifdef BDT_S_BIT_EN
                    s_bit_d = s_bit;
`endif
                    state_d = S_BASE_REQ;
                end
            end
            S_BASE_REQ: begin
                bus.read_en  = 1'b1;
                bus.read_reg = rn_q;
                state_d      = S_BASE_WAIT;
            end
            S_BASE_WAIT: begin
                base_d  = bus.read_value;
                cnt_d   = scan_cnt;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                addr_d  = start_addr & ALIGN_MASK;
                wb_d    = up_q ? (base_q + n_bytes) : (base_q - n_bytes);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = load_q ? S_MEM_REQ : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                bus.read_en  = 1'b1;
                bus.read_reg = 4'(scan_idx);
`ifdef BDT_S_BIT_EN
                bus.read_user_bank = s_bit_q;
`endif
                state_d      = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                data_d  = bus.read_value;
                state_d = S_MEM_WR;
            end
            S_MEM_WR: begin
                bus.data_write_word_en      = 1'b1;
                bus.data_write_word_address = addr_q;
                bus.data_write_word_data    = data_q;
                addr_d  = addr_q + STRIDE;
                mask_d  = mask_q & ~(list_t'(1) << scan_idx);
                state_d = scan_last ? after_xfer : S_RD_REQ;
            end
            S_MEM_REQ: begin
                bus.data_read_word_en      = 1'b1;
                bus.data_read_word_address = addr_q;
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                data_d  = bus.data_read_word_data;
                state_d = S_RF_WR;
            end
            S_RF_WR: begin
                bus.write_en    = 1'b1;
                bus.write_reg   = 4'(scan_idx);
                bus.write_value = data_q;
`ifdef BDT_S_BIT_EN
                bus.write_restore_from_SPSR = s_bit_q && (4'(scan_idx) == 4'd15);
`endif
                addr_d  = addr_q + STRIDE;
                mask_d  = mask_q & ~(list_t'(1) << scan_idx);
                state_d = scan_last ? after_xfer : S_MEM_REQ;
            end
            S_WB: begin
                bus.write_en    = 1'b1;
                bus.write_reg   = rn_q;
                bus.write_value = wb_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= 1'b0;
            up_q    <= 1'b0;
            write_q <= 1'b0;
            load_q  <= 1'b0;
            rn_q    <= '0;
            list_q  <= '0;
            mask_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wb_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef BDT_S_BIT_EN
            s_bit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            up_q    <= up_d;
            write_q <= write_d;
            load_q  <= load_d;
            rn_q    <= rn_d;
            list_q  <= list_d;
            mask_q  <= mask_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef BDT_S_BIT_EN
            s_bit_q <= s_bit_d;
`endif
        end
    end

endmodule

// File: doc/block_data_transfer.md
Name: block_data_transfer

Overview:
- Parametrised multi-register load/store engine (LDM/STM) for the ARM7 core.
- Successor to the single-data-transfer unit: it moves N registers per instruction instead of one.
- Shares the register_file read/write ports and the data_memory word ports with the sdt unit; the decoder selects which unit drives them.
- Supports all four addressing modes (IA/IB/DA/DB), base write-back and an empty-list fast path.

Parameters:
- REG_LIST_WIDTH, 16: number of registers addressable by reg_list; index i maps to register i.
- DATA_WIDTH, 32: register, word and address width.
- WORD_BYTES, 4: address stride per transferred register.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- en  in  1  start pulse; sampled only in IDLE
- pre  in  1  1 = increment/decrement before each access
- up  in  1  1 = ascending addresses from base, 0 = descending
- write  in  1  base write-back enable
- load  in  1  1 = LDM, 0 = STM
- rn  in  4  base register
- reg_list  in  REG_LIST_WIDTH  register bitmap
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse at completion
- write_en / write_reg[3:0] / write_value[DATA_WIDTH] / write_restore_from_SPSR  out  register-file write port
- read_en / read_reg[3:0]  out  register-file read request
- read_value  in  DATA_WIDTH  valid the cycle after read_en
- data_write_word_en / data_write_word_address / data_write_word_data  out  memory word write
- data_read_word_en / data_read_word_address  out  memory word read request
- data_read_word_data  in  DATA_WIDTH  valid the cycle after the request

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0: busy, done, every *_en, write_restore_from_SPSR, all addresses and data.
  - Reset mid-operation aborts immediately. No write-back occurs; memory writes already issued are not undone.
- Accept: in IDLE with en=1, latch all instruction inputs and assert busy the next cycle. en is ignored while busy.
- States:
  - IDLE → BASE_REQ (read_en, read_reg=rn) → BASE_WAIT (latch base from read_value; N = popcount(reg_list)) → SETUP.
  - SETUP computes the start address:
    - IA: base
    - IB: base + 4
    - DA: base − 4N + 4
    - DB: base − 4N
  - SETUP also computes wb = up ? base + 4N : base − 4N.
  - All arithmetic is modulo 2^DATA_WIDTH. The bus address has bits [1:0] forced to 0.
- Register order: always lowest-numbered set bit first, at the lowest address; the address increments by WORD_BYTES per register regardless of up.
- STM, per register: RD_REQ (read_en) → RD_WAIT → MEM_WR (data_write_word_en for 1 cycle). 3 cycles per register.
- LDM, per register: MEM_REQ (data_read_word_en) → MEM_WAIT → RF_WR (write_en for 1 cycle, value = data_read_word_data). 3 cycles per register.
- After the last register → WB if write=1, else → DONE.
  - WB: write_en=1, write_reg=rn, write_value=wb.
  - DONE: done=1, busy=0, then → IDLE.
- Empty reg_list: no transfers and no write-back; SETUP → DONE directly.
- STM with rn in reg_list: stores the original base value.
- LDM with rn in reg_list and write=1: write-back is suppressed; the loaded value wins.
- The unit never asserts write_en and read_en in the same cycle.
- The unit never asserts both memory enables in the same cycle.

Optional Feature:
- Macro: BDT_S_BIT_EN.
- When defined:
  - Adds input s_bit (1 bit), latched at accept.
  - For an LDM with s_bit=1 and register 15 in the list, the R15 write asserts write_restore_from_SPSR together with write_en.
  - For an STM with s_bit=1, register reads use user-bank registers via the existing register_file mode path.
- When undefined: there is no s_bit port and write_restore_from_SPSR is tied to 0.

Decomposition:
- Shared package arm7_bdt_pkg holds:
  - the state enum
  - WORD_BYTES
  - addressing-mode encodings (IA/IB/DA/DB from {pre, up})
- One sub-module, bdt_reg_scan: combinational popcount of reg_list plus next-set-bit finder (input: remaining mask; outputs: index, last flag). It is instantiated once.

Test Plan:
- Setup: R1=0x100, R2=0x11, R3=0x22, R4=0x33. STMIA R1!, {R2,R3,R4} (pre=0, up=1, write=1) → mem[0x100]=0x11, mem[0x104]=0x22, mem[0x108]=0x33; R1=0x10C; done after 13 cycles of busy.
- LDMDB R1, {R5,R6} with R1=0x10C and write=0 → R5=0x22, R6=0x33; R1 unchanged at 0x10C.
- STMDA R1!, {R2} with R1=0x200 → mem[0x200]=0x11; R1=0x1FC. Then STMIB from 0x1FC → address 0x200.
- LDMIA R1!, {R1,R7} with R1=0x100, mem[0x100]=0x500 → R1=0x500 (write-back suppressed); R7 = mem[0x104].
- reg_list=0 with write=1 → no memory or register writes; done pulses; R1 unchanged. Then a new en while busy is ignored.
- Assert rst during the second register of a 3-register STM → no third write and no write-back; busy=0 the cycle after reset.
